// File: rtl/cplx_mult_pkg.sv
// Shared definitions for the sequential complex multiplier: state encoding,
// datapath control encodings, width helpers and op_data field positions.
package cplx_mult_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        DONE = 3'd5
    } cm_state_e;

    typedef enum logic [1:0] {
        MAC_HOLD = 2'd0,
        MAC_LOAD = 2'd1,
        MAC_ADD  = 2'd2,
        MAC_SUB  = 2'd3
    } mac_op_e;

    typedef enum logic [1:0] {
        SEL_A_C = 2'd0,
        SEL_B_D = 2'd1,
        SEL_A_D = 2'd2,
        SEL_B_C = 2'd3
    } mul_sel_e;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Field numbers within op_data; multiply by DATA_WIDTH for the bit offset.
    localparam int unsigned OP1_RE_FIELD = 3;
    localparam int unsigned OP1_IM_FIELD = 2;
    localparam int unsigned OP2_RE_FIELD = 1;
    localparam int unsigned OP2_IM_FIELD = 0;

    function automatic int unsigned prod_width(input int unsigned dw);
        return 2 * dw;
    endfunction

    function automatic int unsigned res_width(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

    function automatic int unsigned op_width(input int unsigned dw);
        return 4 * dw;
    endfunction

endpackage

// File: rtl/cplx_mult_seq_core_mac.sv
// Single signed multiplier feeding one of two RES_WIDTH accumulators with
// load/add/subtract control; acc_nxt exposes the value being written this cycle.
import cplx_mult_pkg::*;

module cplx_mac_unit #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RES_WIDTH  = res_width(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         sw_rst,
    input  logic signed [DATA_WIDTH-1:0] mul_x,
    input  logic signed [DATA_WIDTH-1:0] mul_y,
    input  mac_op_e                      mac_op,
    input  logic                         acc_sel,
    output logic signed [RES_WIDTH-1:0]  re_acc,
    output logic signed [RES_WIDTH-1:0]  im_acc,
    output logic signed [RES_WIDTH-1:0]  acc_nxt
);

    localparam int unsigned PW = prod_width(DATA_WIDTH);

    logic signed [PW-1:0]        prod;
    logic signed [RES_WIDTH-1:0] prod_ext;
    logic signed [RES_WIDTH-1:0] acc_cur;

    assign prod     = mul_x * mul_y;
    assign prod_ext = {{(RES_WIDTH-PW){prod[PW-1]}}, prod};
    assign acc_cur  = acc_sel ? im_acc : re_acc;

    always_comb begin
        acc_nxt = acc_cur;
        case (mac_op)
            MAC_LOAD: acc_nxt = prod_ext;
            MAC_ADD:  acc_nxt = acc_cur + prod_ext;
            MAC_SUB:  acc_nxt = acc_cur - prod_ext;
            default:  acc_nxt = acc_cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            re_acc <= '0;
            im_acc <= '0;
        end else if (mac_op != MAC_HOLD) begin
            if (acc_sel) im_acc <= acc_nxt;
            else         re_acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/cplx_mult_seq_core.sv
// Sequential complex multiplier: accepts {a,b,c,d} under op_val/op_ready and
// returns {a*c-b*d, a*d+b*c} under res_val/res_ready using one shared multiplier.
import cplx_mult_pkg::*;

module cplx_mult_seq_core #(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RES_WIDTH  = res_width(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          sw_rst,
    input  logic                          op_val,
    output logic                          op_ready,
    input  logic [op_width(DATA_WIDTH)-1:0] op_data,
    output logic                          res_val,
    input  logic                          res_ready,
    output logic [2*RES_WIDTH-1:0]        res_data
);

    cm_state_e state_q, state_d;
    mac_op_e   mac_op;
    mul_sel_e  mul_sel;
    logic      acc_sel;
    logic      accept;
    logic      finish;
    logic      handoff;

    logic signed [DATA_WIDTH-1:0] op_a, op_b, op_c, op_d;
    logic signed [DATA_WIDTH-1:0] mul_x, mul_y;
    logic signed [RES_WIDTH-1:0]  re_acc, im_acc, acc_nxt;

    assign op_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (sw_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        mac_op  = MAC_HOLD;
        mul_sel = SEL_A_C;
        acc_sel = 1'b0;
        accept  = 1'b0;
        finish  = 1'b0;
        handoff = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_val) begin
                    accept  = 1'b1;
                    state_d = MUL0;
                end
            end
            MUL0: begin
                mac_op  = MAC_LOAD;
                mul_sel = SEL_A_C;
                state_d = MUL1;
            end
            MUL1: begin
                mac_op  = MAC_SUB;
                mul_sel = SEL_B_D;
                state_d = MUL2;
            end
            MUL2: begin
                mac_op  = MAC_LOAD;
                mul_sel = SEL_A_D;
                acc_sel = 1'b1;
                state_d = MUL3;
            end
            MUL3: begin
                mac_op  = MAC_ADD;
                mul_sel = SEL_B_C;
                acc_sel = 1'b1;
                finish  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    handoff = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mul_x = op_a;
        mul_y = op_c;
        case (mul_sel)
            SEL_A_C: begin mul_x = op_a; mul_y = op_c; end
            SEL_B_D: begin mul_x = op_b; mul_y = op_d; end
            SEL_A_D: begin mul_x = op_a; mul_y = op_d; end
            SEL_B_C: begin mul_x = op_b; mul_y = op_c; end
            default: begin mul_x = op_a; mul_y = op_c; end
        endcase
    end

    cplx_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .RES_WIDTH  (RES_WIDTH)
    ) u_mac (
        .clk     (clk),
        .sw_rst  (sw_rst),
        .mul_x   (mul_x),
        .mul_y   (mul_y),
        .mac_op  (mac_op),
        .acc_sel (acc_sel),
        .re_acc  (re_acc),
        .im_acc  (im_acc),
        .acc_nxt (acc_nxt)
    );

    // im_acc is written on the same edge as res_data, so take its next value.
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            op_d     <= '0;
            res_data <= '0;
            res_val  <= 1'b0;
        end else begin
            if (accept) begin
                op_a <= op_data[OP1_RE_FIELD*DATA_WIDTH +: DATA_WIDTH];
                op_b <= op_data[OP1_IM_FIELD*DATA_WIDTH +: DATA_WIDTH];
                op_c <= op_data[OP2_RE_FIELD*DATA_WIDTH +: DATA_WIDTH];
                op_d <= op_data[OP2_IM_FIELD*DATA_WIDTH +: DATA_WIDTH];
            end
            if (finish) begin
                res_data <= {re_acc, acc_nxt};
                res_val  <= 1'b1;
            end
            if (handoff) res_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cplx_mult_seq_core.sv
// Self-checking bench for cplx_mult_seq_core: directed corners plus random
// transactions compared against an integer-arithmetic reference model.
module tb_cplx_mult_seq_core;

    localparam int DW = 8;
    localparam int RW = 2 * DW + 1;

    logic              clk = 1'b0;
    logic              sw_rst = 1'b1;
    logic              op_val = 1'b0;
    logic              op_ready;
    logic [4*DW-1:0]   op_data = '0;
    logic              res_val;
    logic              res_ready = 1'b0;
    logic [2*RW-1:0]   res_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cplx_mult_seq_core #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .sw_rst    (sw_rst),
        .op_val    (op_val),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .res_val   (res_val),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer complex product, truncated to the result width.
    function automatic logic [2*RW-1:0] ref_model(input logic [DW-1:0] a, b, c, d);
        int ia, ib, ic, id, re, im;
        logic [31:0] re_v, im_v;
        ia = int'($signed(a)); ib = int'($signed(b));
        ic = int'($signed(c)); id = int'($signed(d));
        re = ia * ic - ib * id;
        im = ia * id + ib * ic;
        re_v = re;
        im_v = im;
        return {re_v[RW-1:0], im_v[RW-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, b, c, d);
        int t;
        t = 0;
        while (!op_ready && t < 20) begin step(); t++; end
        if (!op_ready) check("op_ready_timeout", 0, 1);
        op_data = {a, b, c, d};
        op_val  = 1'b1;
        step();
        op_val  = 1'b0;
    endtask

    // Called right after the accepting edge; checks latency and the result.
    task automatic collect(input string tag, input logic [2*RW-1:0] exp, output int seen_cyc);
        int lat;
        lat = 1;
        while (!res_val && lat < 20) begin step(); lat++; end
        seen_cyc = cyc;
        if (!res_val) check({tag, "_timeout"}, 0, 1);
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_data"}, 64'(res_data), 64'(exp));
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_val_clr"}, 64'(res_val), 64'd0);
        check({tag, "_ready_set"}, 64'(op_ready), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] a, b, c, d;
        logic [2*RW-1:0] held;
        int t0, t1, tprev, dummy;
        logic saw_val;

        // Reset state
        sw_rst = 1'b1;
        step(); step();
        sw_rst = 1'b0;
        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_res_val", 64'(res_val), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);

        // Selected values: 2,3,4,2 -> re=2, im=16
        send(8'd2, 8'd3, 8'd4, 8'd2);
        collect("basic", {17'd2, 17'd16}, dummy);
        check("basic_model", 64'(ref_model(8'd2, 8'd3, 8'd4, 8'd2)), 64'({17'd2, 17'd16}));
        consume("basic");

        // Corners
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        collect("ones", {17'd0, 17'd2}, dummy);
        consume("ones");
        send(8'h80, 8'h80, 8'h80, 8'h80);
        collect("min", {17'd0, 17'h08000}, dummy);
        consume("min");

        // Backpressure with ignored op_val pulses
        a = 8'd7; b = 8'hF9; c = 8'd100; d = 8'h85;
        send(a, b, c, d);
        collect("bp", ref_model(a, b, c, d), dummy);
        held = res_data;
        for (int i = 0; i < 10; i++) begin
            op_val  = 1'($urandom_range(0, 1));
            op_data = $urandom;
            step();
            check("bp_hold_data", 64'(res_data), 64'(held));
            check("bp_op_ready", 64'(op_ready), 64'd0);
            check("bp_res_val", 64'(res_val), 64'd1);
        end
        op_val = 1'b0;
        consume("bp");

        // Reset while in MUL2
        send(8'd50, 8'd60, 8'd70, 8'd80);
        step(); step();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        check("midrst_op_ready", 64'(op_ready), 64'd1);
        check("midrst_res_val", 64'(res_val), 64'd0);
        check("midrst_res_data", 64'(res_data), 64'd0);
        saw_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (res_val) saw_val = 1'b1;
        end
        check("midrst_no_result", 64'(saw_val), 64'd0);

        // Back-to-back with res_ready tied high
        res_ready = 1'b1;
        tprev = 0;
        for (int i = 0; i < 3; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            send(a, b, c, d);
            collect("b2b", ref_model(a, b, c, d), t1);
            if (i > 0) check("b2b_spacing", 64'(t1 - tprev), 64'd6);
            tprev = t1;
        end
        step();
        res_ready = 1'b0;
        check("b2b_idle", 64'(op_ready), 64'd1);

        // Handoff collision in DONE
        send(8'd9, 8'hF0, 8'd33, 8'd5);
        collect("coll1", ref_model(8'd9, 8'hF0, 8'd33, 8'd5), dummy);
        a = 8'hC3; b = 8'd45; c = 8'h91; d = 8'd127;
        op_data   = {a, b, c, d};
        op_val    = 1'b1;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("coll_val_clr", 64'(res_val), 64'd0);
        check("coll_not_accepted", 64'(op_ready), 64'd1);
        step();
        op_val = 1'b0;
        check("coll_accepted", 64'(op_ready), 64'd0);
        collect("coll2", ref_model(a, b, c, d), dummy);
        consume("coll2");

        // Random transactions with random consumer delay
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
            send(a, b, c, d);
            collect("rand", ref_model(a, b, c, d), t0);
            held = res_data;
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
            check("rand_stable", 64'(res_data), 64'(held));
            consume("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cplx_mult_seq_core.md
Name: cplx_mult_seq_core

Overview:
Synthesizable responder for the operand/result handshake that the complex multiplier bench drives. It accepts two signed complex operands on op_data under an op_val/op_ready handshake and computes their product with a single shared multiplier over four cycles. It holds the result under a res_val/res_ready handshake. It is the DUT-side end of the interface the bench initiates.

Parameters:
DATA_WIDTH, 8, width of each operand component (signed two's complement).
RES_WIDTH, 2*DATA_WIDTH+1, width of each result component. Derived; not overridden.

Ports:
clk  input  1  clock; all logic on rising edge.
sw_rst  input  1  reset, synchronous, active-high.
op_val  input  1  operands on op_data are valid.
op_ready  output  1  block can accept operands.
op_data  input  4*DATA_WIDTH  {op1_re, op1_im, op2_re, op2_im}, MSB first.
res_val  output  1  res_data is valid.
res_ready  input  1  consumer accepts the result.
res_data  output  2*RES_WIDTH  {res_re, res_im}, MSB first, signed.

Behaviour:
- Reset: any cycle with sw_rst=1 forces state to IDLE and clears operand registers, accumulators, res_data and res_val to 0. In the cycle after reset, op_ready=1, res_val=0 and res_data=0.
- Reset mid-operation (any MUL state or DONE): the in-flight transaction is dropped and no res_val pulse is produced.
- Notation: a=op1_re, b=op1_im, c=op2_re, d=op2_im, all sign-extended.
- Results: res_re = a*c - b*d; res_im = a*d + b*c.
- Each product is 2*DATA_WIDTH bits. Sums are done at RES_WIDTH, so there is no overflow in any case, including all components equal to -2^(DATA_WIDTH-1).
- FSM states: IDLE, MUL0, MUL1, MUL2, MUL3, DONE.
- op_ready is decoded from the state: 1 only in IDLE.
- IDLE: on op_val=1, latch op_data into a..d and go to MUL0. op_data is sampled only on this accepting edge.
- MUL0: re_acc <= a*c.
- MUL1: re_acc <= re_acc - b*d.
- MUL2: im_acc <= a*d.
- MUL3: im_acc <= im_acc + b*c; res_data loaded from the accumulators; res_val <= 1; go to DONE.
- Latency: res_val is first high after exactly 5 rising edges counted from the accepting edge (inclusive).
- DONE: res_val=1 and res_data stays stable until an edge with res_ready=1. On that edge res_val <= 0 and the state returns to IDLE; res_data keeps its value.
- Throughput: one transaction per 6 cycles minimum (accept, 4 MUL cycles, handoff).
- op_val while op_ready=0 is ignored and has no side effects.
- res_ready while res_val=0 is ignored.
- Simultaneous events:
  - res_ready=1 and op_val=1 in DONE: only the result handoff occurs. The new operands are accepted no earlier than the next cycle, in IDLE.
  - sw_rst=1 wins over every other input.
- Exactly one multiplier instance. Its operand muxes are selected by state: (a,c), (b,d), (a,d), (b,c).

Decomposition:
- Shared package cplx_mult_pkg holds:
  - state encoding constants (IDLE=0, MUL0=1, MUL1=2, MUL2=3, MUL3=4, DONE=5, 3-bit state)
  - width helper constants derived from DATA_WIDTH
  - operand field index constants for unpacking op_data
- Sub-module cplx_mac_unit: a signed DATA_WIDTH x DATA_WIDTH multiplier with add/sub/load control into a RES_WIDTH accumulator. It is instantiated once and the top FSM steers its operands.

Test Plan:
- Selected values: a=2, b=3, c=4, d=2, one op_val pulse, res_ready held 1 -> res_re=2, res_im=16; res_val rises exactly 5 edges after the accepting edge, inclusive.
- Corner all-ones (DATA_WIDTH=8, every component 8'hFF = -1) -> res_re=0, res_im=2. All components 8'h80 (-128) -> res_re=0, res_im=32768 (17-bit 0x08000), with no sign wrap.
- Backpressure: after res_val=1 hold res_ready=0 for 10 cycles while pulsing op_val with new data -> res_data unchanged, op_ready=0 throughout, new data never consumed. Then a res_ready pulse -> res_val=0 and op_ready=1 on the next cycle.
- Reset mid-operation: assert sw_rst for 1 cycle while in MUL2 -> next cycle op_ready=1, res_val=0, res_data=0; no result appears for the aborted transaction.
- Back-to-back: 3 random operand sets, each op_val asserted as soon as op_ready=1 and res_ready tied 1 -> 3 results matching the reference model, in order, 6 cycles apart.
- Handoff collision: in DONE, assert res_ready and op_val together with new data -> result consumed; operands are accepted only on the following edge in IDLE, and the second result is correct.
